// File: rtl/mbist_repair_scan_ctrl.sv
// mbist_repair_scan_ctrl
//   Sequencer for the serial scan chain of the MBIST repair-address table.
//   A command captures the repair entries into the chain (bist_load). The
//   controller then shifts the chain out one segment at a time through sdo
//   and hands each captured word to the host. In exchange mode, host words
//   are shifted in on sdi during the same shift cycles.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_xchg  start request (taken in IDLE only); 1 = exchange
//   busy, done          operation in progress / one-cycle completion pulse
//   in_data/in_valid/in_ready    host word to shift in (exchange mode)
//   out_data/out_idx/out_valid/out_ready  captured entry back to the host
//   bist_load, bist_shift, sdi, sdo       scan-chain control and data
//
// Handshakes: a word moves on a rising edge where valid && ready are both
// high. Once the controller raises out_valid, it holds out_data/out_idx
// stable until that edge. in_ready and out_valid are decoded from state
// only, so neither depends combinationally on in_valid or out_ready.
module mbist_repair_scan_ctrl #(
  parameter int BIST_ERR_LIMIT = 4,
  parameter int SEG_WD         = 16,
  localparam int IDX_W = (BIST_ERR_LIMIT > 1) ? $clog2(BIST_ERR_LIMIT) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic              cmd_xchg,
  output logic              busy,
  output logic              done,
  input  logic [SEG_WD-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SEG_WD-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              bist_load,
  output logic              bist_shift,
  output logic              sdi,
  input  logic              sdo
);

  localparam int BIT_W = $clog2(SEG_WD);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SEG_WD - 1);
  localparam logic [IDX_W-1:0] LAST_SEG = IDX_W'(BIST_ERR_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_IN,
    S_SHIFT,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic              mode;
  logic [IDX_W-1:0]  seg_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SEG_WD-1:0] rx_sr;
  logic [SEG_WD-1:0] tx_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode    <= 1'b0;
      seg_cnt <= '0;
      bit_cnt <= '0;
      rx_sr   <= '0;
      tx_sr   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            mode    <= cmd_xchg;
            seg_cnt <= '0;
          end
        end
        S_WAIT_IN: begin
          if (in_valid) tx_sr <= in_data;
        end
        S_SHIFT: begin
          // sdo is sampled on the same edge the chain shifts, so this
          // captures the pre-shift tail bit.
          rx_sr   <= {rx_sr[SEG_WD-2:0], sdo};
          tx_sr   <= {tx_sr[SEG_WD-2:0], 1'b0};
          bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
        S_PRESENT: begin
          if (out_ready && (seg_cnt != LAST_SEG)) seg_cnt <= seg_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (cmd_valid) state_nx = S_LOAD;
      S_LOAD:    state_nx = mode ? S_WAIT_IN : S_SHIFT;
      S_WAIT_IN: if (in_valid) state_nx = S_SHIFT;
      S_SHIFT:   if (bit_cnt == LAST_BIT) state_nx = S_PRESENT;
      S_PRESENT: begin
        if (out_ready) begin
          if (seg_cnt == LAST_SEG) state_nx = S_DONE;
          else                     state_nx = mode ? S_WAIT_IN : S_SHIFT;
        end
      end
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Every output is a decode of registered state, so nothing glitches on
  // host-side inputs. The chain emits entry BIST_ERR_LIMIT-1 first, hence
  // the reversed index.
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign bist_load  = (state == S_LOAD);
  assign bist_shift = (state == S_SHIFT);
  assign in_ready   = (state == S_WAIT_IN);
  assign out_valid  = (state == S_PRESENT);
  assign out_data   = (state == S_PRESENT) ? rx_sr : '0;
  assign out_idx    = (state == S_PRESENT) ? (LAST_SEG - seg_cnt) : '0;
  assign sdi        = (state == S_SHIFT) & mode & tx_sr[SEG_WD-1];

endmodule
